// File: rtl/reaction_timer.sv
// Reaction timer: counts prescaled ticks from a start pulse to a stop pulse (or a
// latched timeout limit) and holds the result under a valid/ack handshake.
module reaction_timer #(
    parameter int N        = 16,
    parameter int PRESCALE = 1000
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         stop,
    input  logic [N-1:0] max_count,
    input  logic         result_ack,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] elapsed,
    output logic         timed_out
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [N-1:0]  count;
    logic [N-1:0]  limit;
    logic          tick;

    assign tick = (presc == PMAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            presc     <= '0;
            count     <= '0;
            limit     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            elapsed   <= '0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        presc <= '0;
                        count <= '0;
                        limit <= max_count;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Any tick landing on the stop edge is not counted.
                        state     <= DONE;
                        elapsed   <= count;
                        timed_out <= 1'b0;
                        busy      <= 1'b0;
                        valid     <= 1'b1;
                    end else if (start) begin
                        presc <= '0;
                        count <= '0;
                        limit <= max_count;
                    end else if (tick) begin
                        presc <= '0;
                        if (count == limit) begin
                            state     <= DONE;
                            elapsed   <= limit;
                            timed_out <= 1'b1;
                            busy      <= 1'b0;
                            valid     <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state     <= RUN;
                        presc     <= '0;
                        count     <= '0;
                        limit     <= max_count;
                        busy      <= 1'b1;
                        valid     <= 1'b0;
                        timed_out <= 1'b0;
                    end else if (result_ack) begin
                        state     <= IDLE;
                        valid     <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reaction_timer.sv
// Scoreboarded bench for reaction_timer (N=8, PRESCALE=4): stimulus pushes the
// expected result, a negedge monitor pops it when valid rises.
module tb_reaction_timer;

    localparam int N = 8;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b1;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [N-1:0] max_count = '0;
    logic         result_ack = 1'b0;
    logic         busy, valid, timed_out;
    logic [N-1:0] elapsed;

    typedef struct {
        int e;
        int t;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    reaction_timer #(.N(N), .PRESCALE(P)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .max_count  (max_count),
        .result_ack (result_ack),
        .busy       (busy),
        .valid      (valid),
        .elapsed    (elapsed),
        .timed_out  (timed_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: measurement starts at edge 0; stop sampled at edge k (0 = never).
    // Ticks complete at edges P,2P,..; timeout fires on the tick at edge P*(L+1).
    function automatic exp_t model(input int L, input int k);
        exp_t r;
        if (k != 0 && k <= P * (L + 1)) begin
            r.e = (k - 1) / P;
            r.t = 0;
        end else begin
            r.e = L;
            r.t = 1;
        end
        return r;
    endfunction

    // Monitor: compare on valid rising, check hold stability while valid stays high.
    logic valid_q = 1'b0;
    int   held_e, held_t;
    always @(negedge clk) begin
        if (valid === 1'b1 && valid_q !== 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: elapsed %0d with empty scoreboard", elapsed);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("elapsed", int'(elapsed), e.e);
                chk("timed_out", int'(timed_out), e.t);
            end
            held_e = int'(elapsed);
            held_t = int'(timed_out);
        end else if (valid === 1'b1) begin
            chk("elapsed_hold", int'(elapsed), held_e);
            chk("timed_out_hold", int'(timed_out), held_t);
        end
        valid_q = valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One measurement: start (limit L), optional restart r edges later with limit L2,
    // stop k edges after the effective start, then hold and ack (or leave in DONE).
    task automatic run_meas(input int L, input int r, input int L2, input int k,
                            input int hold, input bit end_ack, input bit ack_with_start);
        int  effL;
        bit  got;
        start      = 1'b1;
        max_count  = N'(L);
        result_ack = ack_with_start;
        step();
        start      = 1'b0;
        result_ack = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        chk("valid_after_start", int'(valid), 0);
        effL = L;
        if (r > 0) begin
            repeat (r - 1) step();
            start     = 1'b1;
            max_count = N'(L2);
            step();
            start = 1'b0;
            chk("busy_after_restart", int'(busy), 1);
            effL = L2;
        end
        sb.push_back(model(effL, k));
        if (k > 0) begin
            repeat (k - 1) step();
            stop = 1'b1;
            step();
            stop = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (valid) begin
                got = 1'b1;
                break;
            end
            step();
        end
        if (!got) chk("valid_wait_timeout", 0, 1);
        repeat (hold) step();
        if (end_ack) begin
            result_ack = 1'b1;
            step();
            result_ack = 1'b0;
            chk("valid_after_ack", int'(valid), 0);
            chk("busy_after_ack", int'(busy), 0);
        end
    endtask

    initial begin
        // Reset asserted mid-cycle, away from any edge.
        #3 reset_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_timed_out", int'(timed_out), 0);
        chk("rst_elapsed", int'(elapsed), 0);
        #20 reset_n = 1'b1;
        step();

        run_meas(50, 0, 0, 10, 0, 1'b1, 1'b0);  // elapsed 2
        run_meas(3, 0, 0, 0, 0, 1'b1, 1'b0);    // timeout at edge 16
        run_meas(50, 0, 0, 8, 0, 1'b1, 1'b0);   // stop on tick edge -> 1
        run_meas(1, 0, 0, 8, 5, 1'b1, 1'b0);    // stop beats timeout, long hold
        run_meas(0, 0, 0, 0, 2, 1'b0, 1'b0);    // limit 0 timeout, stay in DONE
        run_meas(50, 0, 0, 6, 1, 1'b1, 1'b1);   // start+ack together in DONE
        run_meas(50, 6, 50, 5, 0, 1'b1, 1'b0);  // restart mid-run -> 1

        for (int it = 0; it < 40; it++) begin
            int L, r, L2, k;
            L  = $urandom_range(0, 15);
            r  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, P * (L + 1) - 1) : 0;
            L2 = $urandom_range(0, 15);
            k  = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 80);
            run_meas(L, r, L2, k, $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end
        if (valid) begin
            result_ack = 1'b1;
            step();
            result_ack = 1'b0;
        end

        // Mid-run reset discards the measurement; a later stop must be ignored.
        start     = 1'b1;
        max_count = 8'd50;
        step();
        start = 1'b0;
        repeat (5) step();
        #2 reset_n = 1'b0;
        #1;
        chk("midrun_rst_busy", int'(busy), 0);
        chk("midrun_rst_valid", int'(valid), 0);
        #10 reset_n = 1'b1;
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("stop_after_reset_valid", int'(valid), 0);
            chk("stop_after_reset_busy", int'(busy), 0);
            step();
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
